// File: rtl/text_render.sv
// Text-mode pixel pipeline: pixel coordinate -> text RAM fetch -> font ROM row -> RGB pixel,
// with sync/valid delayed to match and a blinking underline cursor.
module text_render #(
    parameter int          COLS       = 80,
    parameter int          ROWS       = 60,
    parameter logic [11:0] FG         = 12'hFFF,
    parameter logic [11:0] BG         = 12'h000,
    parameter int          BLINK_LOG2 = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_en,
    input  logic [9:0]  in_x,
    input  logic [9:0]  in_y,
    input  logic        in_valid,
    input  logic        in_hs,
    input  logic        in_vs,
    output logic [12:0] char_addr,
    input  logic [7:0]  char_data,
    output logic [7:0]  font_ascii,
    output logic [3:0]  font_line,
    input  logic [7:0]  font_row,
    input  logic [6:0]  cursor_x,
    input  logic [5:0]  cursor_y,
    input  logic        cursor_en,
    output logic [11:0] pix_rgb,
    output logic        out_hs,
    output logic        out_vs,
    output logic        out_valid
);

    localparam logic [6:0] COLS_W = 7'(COLS);
    localparam logic [6:0] ROWS_W = 7'(ROWS);

    // S0 -> S1 registers (the text RAM output is aligned with these)
    logic [9:0] s1_x;
    logic [9:0] s1_y;
    logic       s1_valid;
    logic       s1_hs;
    logic       s1_vs;

    // S1 -> S2 registers
    logic [7:0] s2_row;
    logic [2:0] s2_xl;
    logic       s2_inv;
    logic       s2_cur;
    logic       s2_valid;
    logic       s2_hs;
    logic       s2_vs;

    // cursor blink state
    logic [BLINK_LOG2-1:0] frame_cnt;
    logic                  blink_on;

    logic [12:0] row_w;
    logic [12:0] col_w;
    logic        s1_hit;
    logic        s1_solid;
    logic [7:0]  s1_row;
    logic        vs_rise;
    logic        pix_bit;

    assign row_w = {6'b0, in_y[9:3]};
    assign col_w = {6'b0, in_x[9:3]};

    generate
        if (COLS == 80) begin : g_mul80
            assign char_addr = (row_w << 6) + (row_w << 4) + col_w;
        end else begin : g_mul
            assign char_addr = row_w * 13'(COLS) + col_w;
        end
    endgenerate

    assign font_ascii = {1'b0, char_data[6:0]};
    assign font_line  = {1'b0, s1_y[2:0]};

    // Out-of-range cursor positions are rejected explicitly so they never alias onto the screen.
    assign s1_hit = cursor_en
                 && (cursor_x < COLS_W)
                 && ({1'b0, cursor_y} < ROWS_W)
                 && (s1_x[9:3] == cursor_x)
                 && (s1_y[9:3] == {1'b0, cursor_y})
                 && (s1_y[2:0] == 3'd7);

    assign s1_solid = (char_data[6:0] == 7'h7F);
    assign s1_row   = s1_solid ? 8'hFF : font_row;

    assign vs_rise = in_vs & ~s1_vs;
    assign pix_bit = s2_row[3'd7 - s2_xl] ^ s2_inv ^ (s2_cur & blink_on);

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_x      <= '0;
            s1_y      <= '0;
            s1_valid  <= 1'b0;
            s1_hs     <= 1'b0;
            s1_vs     <= 1'b0;
            s2_row    <= '0;
            s2_xl     <= '0;
            s2_inv    <= 1'b0;
            s2_cur    <= 1'b0;
            s2_valid  <= 1'b0;
            s2_hs     <= 1'b0;
            s2_vs     <= 1'b0;
            pix_rgb   <= '0;
            out_valid <= 1'b0;
            out_hs    <= 1'b0;
            out_vs    <= 1'b0;
            frame_cnt <= '0;
            blink_on  <= 1'b0;
        end else if (pix_en) begin
            s1_x      <= in_x;
            s1_y      <= in_y;
            s1_valid  <= in_valid;
            s1_hs     <= in_hs;
            s1_vs     <= in_vs;

            s2_row    <= s1_row;
            s2_xl     <= s1_x[2:0];
            s2_inv    <= char_data[7];
            s2_cur    <= s1_hit;
            s2_valid  <= s1_valid;
            s2_hs     <= s1_hs;
            s2_vs     <= s1_vs;

            pix_rgb   <= s2_valid ? (pix_bit ? FG : BG) : 12'h000;
            out_valid <= s2_valid;
            out_hs    <= s2_hs;
            out_vs    <= s2_vs;

            // s1_vs holds the previous strobe's vsync level, so it doubles as the edge detector.
            if (vs_rise) begin
                frame_cnt <= frame_cnt + 1'b1;
                if (&frame_cnt)
                    blink_on <= ~blink_on;
            end
        end
    end

endmodule

// File: tb/tb_text_render.sv
// Bench for text_render: text RAM and font ROM models, table vectors, directed cursor/sync/reset
// sequences and randomized pixels scored against a cell-level reference model.
module tb_text_render;

    localparam logic [11:0] FG = 12'hFFF;
    localparam logic [11:0] BG = 12'h000;
    localparam int BLINK_LOG2 = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        pix_en;
    logic [9:0]  in_x;
    logic [9:0]  in_y;
    logic        in_valid;
    logic        in_hs;
    logic        in_vs;
    logic [12:0] char_addr;
    logic [7:0]  char_data;
    logic [7:0]  font_ascii;
    logic [3:0]  font_line;
    logic [7:0]  font_row;
    logic [6:0]  cursor_x;
    logic [5:0]  cursor_y;
    logic        cursor_en;
    logic [11:0] pix_rgb;
    logic        out_hs;
    logic        out_vs;
    logic        out_valid;

    text_render #(
        .COLS(80), .ROWS(60), .FG(FG), .BG(BG), .BLINK_LOG2(BLINK_LOG2)
    ) dut (
        .clk(clk), .rst(rst), .pix_en(pix_en),
        .in_x(in_x), .in_y(in_y), .in_valid(in_valid), .in_hs(in_hs), .in_vs(in_vs),
        .char_addr(char_addr), .char_data(char_data),
        .font_ascii(font_ascii), .font_line(font_line), .font_row(font_row),
        .cursor_x(cursor_x), .cursor_y(cursor_y), .cursor_en(cursor_en),
        .pix_rgb(pix_rgb), .out_hs(out_hs), .out_vs(out_vs), .out_valid(out_valid)
    );

    // clock
    always #5 clk = ~clk;

    // memories around the DUT
    logic [7:0] text_ram [0:8191];
    logic [7:0] font_rom [0:127][0:7];

    always @(posedge clk) if (pix_en) char_data <= text_ram[char_addr];
    assign font_row = (font_ascii[7] | font_line[3]) ? 8'h00 : font_rom[font_ascii[6:0]][font_line[2:0]];

    // scoreboard
    int          checks = 0;
    int          errors = 0;
    logic [14:0] exp_q[$];
    logic [14:0] last_out;
    logic [11:0] last_font;
    bit          font_known;
    int          vs_edges;
    logic        prev_vs;
    logic [11:0] seen [0:9];

    typedef struct { int x; int y; logic [12:0] addr; } addr_vec_t;
    typedef struct { logic [7:0] code; logic [7:0] frow; logic [7:0] bits; } pix_vec_t;
    addr_vec_t av [0:7];
    pix_vec_t  pv [0:5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [14:0] obs_now();
        return {out_valid, out_hs, out_vs, pix_rgb};
    endfunction

    // Reference: what the screen should show at (x,y) given the RAM, font, cursor and frame count.
    function automatic logic [14:0] model_pix(input int x, input int y, input logic v,
                                             input logic hs, input logic vs);
        int code, glyph, rowb, b, blink;
        bit hit;
        if (!v) return {1'b0, hs, vs, 12'h000};
        code  = int'(text_ram[((y / 8) * 80 + x / 8) % 8192]);
        glyph = code % 128;
        rowb  = (glyph == 127) ? 255 : int'(font_rom[glyph][y % 8]);
        b     = (rowb >> (7 - x % 8)) % 2;
        if (code >= 128) b = 1 - b;
        hit = cursor_en && (int'(cursor_x) < 80) && (int'(cursor_y) < 60)
              && (x / 8 == int'(cursor_x)) && (y / 8 == int'(cursor_y)) && (y % 8 == 7);
        blink = (vs_edges >> BLINK_LOG2) % 2;
        if (hit && blink == 1) b = 1 - b;
        return {1'b1, hs, vs, (b == 1) ? FG : BG};
    endfunction

    task automatic model_reset();
        exp_q.delete();
        exp_q.push_back(15'h0);
        exp_q.push_back(15'h0);
        vs_edges   = 0;
        prev_vs    = 1'b0;
        last_out   = 15'h0;
        font_known = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        rst      = 1'b1;
        pix_en   = 1'b1;
        in_valid = 1'b1;
        in_hs    = 1'b1;
        in_vs    = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            check("reset_out", 32'(obs_now()), 32'h0);
            check("reset_line", 32'(font_line), 32'h0);
        end
        rst    = 1'b0;
        pix_en = 1'b0;
        model_reset();
    endtask

    // One pixel strobe, preceded by 'gap' idle clocks during which every output must hold.
    task automatic strobe(input int x, input int y, input logic v, input logic hs,
                          input logic vs, input int gap);
        logic [14:0] e;
        int a;
        for (int i = 0; i < gap; i++) begin
            pix_en   = 1'b0;
            in_x     = 10'($urandom_range(0, 1023));
            in_y     = 10'($urandom_range(0, 1023));
            in_valid = 1'($urandom_range(0, 1));
            in_hs    = 1'($urandom_range(0, 1));
            in_vs    = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            check("hold_out", 32'(obs_now()), 32'(last_out));
            if (font_known) check("hold_font", 32'({font_ascii, font_line}), 32'(last_font));
        end
        pix_en   = 1'b1;
        in_x     = 10'(x);
        in_y     = 10'(y);
        in_valid = v;
        in_hs    = hs;
        in_vs    = vs;
        if (vs && !prev_vs) vs_edges++;
        prev_vs = vs;
        a = ((y / 8) * 80 + x / 8) % 8192;
        exp_q.push_back(model_pix(x, y, v, hs, vs));
        @(posedge clk); #1;
        pix_en = 1'b0;
        e = exp_q.pop_front();
        check("pixel", 32'(obs_now()), 32'(e));
        last_out   = e;
        last_font  = {1'b0, text_ram[a][6:0], 1'b0, 3'(y % 8)};
        font_known = 1'b1;
        check("font", 32'({font_ascii, font_line}), 32'(last_font));
    endtask

    task automatic idle_strobes(input int n, input int gap);
        for (int i = 0; i < n; i++) strobe(0, 0, 1'b0, 1'b0, prev_vs, gap);
    endtask

    // Draws x=0..7 of row y in cell column 0 and optionally compares against an expected bit pattern.
    task automatic draw_line(input int y, input logic [7:0] bits, input bit cmp, input string name);
        for (int k = 0; k < 10; k++) begin
            if (k < 8) strobe(k, y, 1'b1, 1'b0, prev_vs, 0);
            else       strobe(0, 0, 1'b0, 1'b0, prev_vs, 0);
            seen[k] = pix_rgb;
        end
        idle_strobes(1, 0);
        if (cmp)
            for (int x = 0; x < 8; x++) check(name, 32'(seen[x + 2]), 32'(bits[7 - x] ? FG : BG));
    endtask

    task automatic vs_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            strobe(0, 0, 1'b0, 1'b0, 1'b1, 0);
            strobe(0, 0, 1'b0, 1'b0, 1'b0, 0);
        end
    endtask

    initial begin
        int cx, cy, x, y;
        for (int i = 0; i < 8192; i++) text_ram[i] = 8'($urandom);
        for (int g = 0; g < 128; g++)
            for (int l = 0; l < 8; l++) font_rom[g][l] = 8'($urandom);
        for (int l = 0; l < 8; l++) font_rom[8'h20][l] = 8'h00;

        av[0] = '{0, 0, 13'd0};     av[1] = '{0, 8, 13'd80};
        av[2] = '{639, 479, 13'd4799}; av[3] = '{8, 0, 13'd1};
        av[4] = '{320, 240, 13'd2440}; av[5] = '{7, 7, 13'd0};
        av[6] = '{632, 0, 13'd79};  av[7] = '{15, 471, 13'd4641};

        pv[0] = '{8'h41, 8'h30, 8'b0011_0000};
        pv[1] = '{8'hC1, 8'h30, 8'b1100_1111};
        pv[2] = '{8'h7F, 8'h00, 8'hFF};
        pv[3] = '{8'hFF, 8'h00, 8'h00};
        pv[4] = '{8'h20, 8'h00, 8'h00};
        pv[5] = '{8'h55, 8'hA5, 8'hA5};

        rst = 1'b0; pix_en = 1'b0; in_x = '0; in_y = '0; in_valid = 1'b0;
        in_hs = 1'b0; in_vs = 1'b0; cursor_x = '0; cursor_y = '0; cursor_en = 1'b0;
        do_reset(3);

        // zero-latency address generation
        for (int i = 0; i < 8; i++) begin
            in_x = 10'(av[i].x);
            in_y = 10'(av[i].y);
            #1;
            check("char_addr", 32'(char_addr), 32'(av[i].addr));
        end

        // glyph row patterns, inverse video and solid block
        for (int i = 0; i < 6; i++) begin
            text_ram[0] = pv[i].code;
            font_rom[pv[i].code[6:0]][0] = pv[i].frow;
            draw_line(0, pv[i].bits, 1'b1, "glyph_row");
        end
        text_ram[0] = 8'hC1;
        strobe(0, 0, 1'b1, 1'b0, 1'b0, 0);
        check("font_ascii_inv", 32'(font_ascii), 32'h41);
        idle_strobes(3, 0);

        // cursor underline with blink
        text_ram[0] = 8'h20;
        cursor_x = 7'd0; cursor_y = 6'd0; cursor_en = 1'b1;
        draw_line(7, 8'h00, 1'b1, "cursor_off");
        vs_pulses(32);
        draw_line(7, 8'hFF, 1'b1, "cursor_on");
        draw_line(0, 8'h00, 1'b1, "cursor_line0");
        draw_line(6, 8'h00, 1'b1, "cursor_line6");
        vs_pulses(32);
        draw_line(7, 8'h00, 1'b1, "cursor_blink_off");
        cursor_en = 1'b0;

        // sparse strobes with toggling syncs
        for (int i = 0; i < 40; i++)
            strobe($urandom_range(0, 639), $urandom_range(0, 479), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3);
        strobe(0, 0, 1'b0, 1'b0, 1'b0, 3);
        idle_strobes(3, 3);

        // reset mid-line
        text_ram[0] = 8'h41;
        font_rom[8'h41][0] = 8'h30;
        for (int i = 0; i < 4; i++) strobe(i * 8 + 3, 0, 1'b1, 1'b1, 1'b0, 0);
        do_reset(1);
        draw_line(0, 8'b0011_0000, 1'b1, "after_reset");

        // blink counter restarted by reset: 32 edges turn it on
        vs_pulses(32);
        cursor_en = 1'b1;
        text_ram[0] = 8'h20;
        draw_line(7, 8'hFF, 1'b1, "reset_blink");

        // randomized pixels, cursor moved (incl. out of range) between flushed groups
        for (int g = 0; g < 12; g++) begin
            cx = $urandom_range(0, 127);
            cy = $urandom_range(0, 63);
            cursor_x  = 7'(cx);
            cursor_y  = 6'(cy);
            cursor_en = 1'($urandom_range(0, 3) != 0);
            for (int i = 0; i < 30; i++) begin
                x = ($urandom_range(0, 1) == 1) ? cx * 8 + $urandom_range(0, 7) : $urandom_range(0, 1023);
                y = ($urandom_range(0, 1) == 1) ? cy * 8 + 7 : $urandom_range(0, 511);
                strobe(x, y, 1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)), 1'b0,
                       $urandom_range(0, 2));
            end
            idle_strobes(3, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
